// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader -- instruction memory with a byte-stream image loader.
//
// The CPU fetches combinationally from mem[pc]. While an image is being
// loaded, setn is held low so the CPU stays frozen at its current pc. Bytes
// arrive low byte first; each low/high pair becomes one word written at an
// internal word address that starts at 0 and wraps at the memory depth.
//
// Parameters:
//   IMSB  instruction word MSB (word is two bytes, IMSB+1 bits)
//   PMSB  program counter MSB, depth = 2**(PMSB+1) words
//
// Ports:
//   clk         clock, all state changes on posedge
//   rstn        asynchronous active-low reset
//   pc          CPU fetch address
//   inst        mem[pc], no latency
//   setn        CPU run enable (low = CPU frozen)
//   load_start  begin an image load (honoured only when idle)
//   load_valid  load_byte valid
//   load_byte   image byte, low byte of each word first
//   load_last   final word marker, looked at with the high byte only
//   load_ready  loader accepts a byte this cycle
//   load_done   one-cycle pulse when the load completes
//   load_cnt    words written in the current/last load, saturates at depth
//
// Build option:
//   IMEM_BOOT_LOAD_EN  when defined, reset enters LOAD_LO so the CPU is held
//                      until the first image has been loaded; otherwise reset
//                      enters IDLE and the CPU runs from existing memory.
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int IMSB = 15,
    parameter int PMSB = 7
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [PMSB:0]   pc,
    output logic [IMSB:0]   inst,
    output logic            setn,
    input  logic            load_start,
    input  logic            load_valid,
    input  logic [7:0]      load_byte,
    input  logic            load_last,
    output logic            load_ready,
    output logic            load_done,
    output logic [PMSB+1:0] load_cnt
);

    localparam int              DEPTH   = 2 ** (PMSB + 1);
    localparam logic [PMSB+1:0] CNT_MAX = (PMSB + 2)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD_LO, LOAD_HI, DONE} state_t;

`ifdef IMEM_BOOT_LOAD_EN
    localparam state_t RST_STATE = LOAD_LO;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t        state, state_nxt;
    logic [PMSB:0] waddr;
    logic [7:0]    lo_byte;
    logic [IMSB:0] mem [DEPTH];

    logic start_load;
    logic lo_xfer;
    logic hi_xfer;

    // load_ready is only high in the two load states, so a transfer there
    // reduces to load_valid.
    assign start_load = (state == IDLE) && load_start;
    assign lo_xfer    = (state == LOAD_LO) && load_valid;
    assign hi_xfer    = (state == LOAD_HI) && load_valid;

    assign inst = mem[pc];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= RST_STATE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        setn       = 1'b0;
        load_ready = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                setn = 1'b1;
                if (load_start) state_nxt = LOAD_LO;
            end
            LOAD_LO: begin
                load_ready = 1'b1;
                if (load_valid) state_nxt = LOAD_HI;
            end
            LOAD_HI: begin
                load_ready = 1'b1;
                if (load_valid) state_nxt = load_last ? DONE : LOAD_LO;
            end
            DONE: begin
                load_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            waddr    <= '0;
            load_cnt <= '0;
            lo_byte  <= '0;
        end else begin
            if (start_load) begin
                waddr    <= '0;
                load_cnt <= '0;
            end
            if (lo_xfer) lo_byte <= load_byte;
            if (hi_xfer) begin
                // waddr wraps naturally at depth; later words overwrite.
                waddr <= waddr + 1'b1;
                if (load_cnt != CNT_MAX) load_cnt <= load_cnt + 1'b1;
            end
        end
    end

    // Memory is deliberately outside the reset domain: an aborted load keeps
    // whatever words were already written.
    always_ff @(posedge clk) begin
        if (hi_xfer) mem[waddr] <= (IMSB + 1)'({load_byte, lo_byte});
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int PMSB  = 1;
    localparam int IMSB  = 15;
    localparam int DEPTH = 4;

`ifdef IMEM_BOOT_LOAD_EN
    localparam bit BOOT = 1'b1;
`else
    localparam bit BOOT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [PMSB:0]   pc = '0;
    logic [IMSB:0]   inst;
    logic            setn;
    logic            load_start = 1'b0;
    logic            load_valid = 1'b0;
    logic [7:0]      load_byte = '0;
    logic            load_last = 1'b0;
    logic            load_ready;
    logic            load_done;
    logic [PMSB+1:0] load_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: memory image plus whether the loader is idle.
    logic [15:0] ref_mem [DEPTH];
    bit          mdl_idle;

    imem_loader #(.IMSB(IMSB), .PMSB(PMSB)) dut (
        .clk(clk), .rstn(rstn), .pc(pc), .inst(inst), .setn(setn),
        .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .load_cnt(load_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus helpers ----------------
    task automatic do_start();
        if (mdl_idle) begin
            load_start = 1'b1;
            @(posedge clk); #1;
            load_start = 1'b0;
            mdl_idle = 1'b0;
        end
    endtask

    // Drive one byte; returns #1 after the posedge at which it transferred.
    task automatic send_byte(input logic [7:0] b, input bit last, input int stall);
        int n;
        repeat (stall) begin @(posedge clk); #1; end
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        n = 0;
        while (!load_ready && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (!load_ready) begin
            errors++;
            $display("FAIL ready_timeout: load_ready=%b after %0d cycles, required 1", load_ready, n);
        end
        @(posedge clk); #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic send_words(input logic [15:0] w [$], input int stall_max);
        do_start();
        for (int i = 0; i < w.size(); i++) begin
            send_byte(w[i][7:0], 1'b0, $urandom_range(0, stall_max));
            send_byte(w[i][15:8], i == w.size() - 1, $urandom_range(0, stall_max));
        end
    endtask

    // Image semantics: word i of a load lands at i mod depth.
    task automatic model_load(input logic [15:0] w [$]);
        for (int i = 0; i < w.size(); i++) ref_mem[i % DEPTH] = w[i];
        mdl_idle = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (setn !== !BOOT) begin errors++; $display("FAIL rst_setn: got %b required %b", setn, !BOOT); end
        checks++; if (load_ready !== BOOT) begin errors++; $display("FAIL rst_ready: got %b required %b", load_ready, BOOT); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", load_done); end
        checks++; if (load_cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt: got %0d required 0", load_cnt); end
        @(negedge clk); rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (setn !== !BOOT) begin errors++; $display("FAIL post_rst_setn: got %b required %b", setn, !BOOT); end
        checks++; if (load_cnt !== 3'd0) begin errors++; $display("FAIL post_rst_cnt: got %0d required 0", load_cnt); end
        mdl_idle = !BOOT;
    endtask

    task automatic test_basic();
        logic [15:0] w [$];
        w = '{16'h1234, 16'h5678};
        pc = 2'd0;
        do_start();
        send_byte(8'h34, 1'b0, 0);
        send_byte(8'h12, 1'b0, 0);
        checks++; if (inst !== 16'h1234) begin errors++; $display("FAIL basic_wr_visible: got %h required 1234", inst); end
        checks++; if (load_cnt !== 3'd1) begin errors++; $display("FAIL basic_cnt1: got %0d required 1", load_cnt); end
        send_byte(8'h78, 1'b0, 0);
        send_byte(8'h56, 1'b1, 0);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b required 1", load_done); end
        checks++; if (setn !== 1'b0) begin errors++; $display("FAIL basic_setn_done: got %b required 0", setn); end
        checks++; if (load_cnt !== 3'd2) begin errors++; $display("FAIL basic_cnt: got %0d required 2", load_cnt); end
        @(posedge clk); #1;
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b required 0", load_done); end
        checks++; if (setn !== 1'b1) begin errors++; $display("FAIL basic_setn_after: got %b required 1", setn); end
        model_load(w);
        pc = 2'd1; #1;
        checks++; if (inst !== ref_mem[1]) begin errors++; $display("FAIL basic_mem1: got %h required %h", inst, ref_mem[1]); end
    endtask

    task automatic test_wrap();
        logic [15:0] w [$];
        w = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        send_words(w, 0);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b required 1", load_done); end
        checks++; if (load_cnt !== 3'd4) begin errors++; $display("FAIL wrap_cnt: got %0d required 4", load_cnt); end
        @(posedge clk); #1;
        model_load(w);
    endtask

    task automatic test_fetch();
        for (int i = 0; i < DEPTH; i++) begin
            pc = i[PMSB:0]; #1;
            checks++;
            if (inst !== ref_mem[i]) begin errors++; $display("FAIL fetch_pc%0d: got %h required %h", i, inst, ref_mem[i]); end
        end
    endtask

    task automatic test_stall();
        do_start();
        send_byte(8'hCD, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (setn !== 1'b0 || load_ready !== 1'b1 || load_cnt !== 3'd0 || load_done !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: setn=%b ready=%b cnt=%0d done=%b required 0 1 0 0", i, setn, load_ready, load_cnt, load_done);
            end
        end
        send_byte(8'hAB, 1'b1, 0);
        checks++; if (load_cnt !== 3'd1) begin errors++; $display("FAIL stall_cnt: got %0d required 1", load_cnt); end
        pc = 2'd0; #1;
        checks++; if (inst !== 16'hABCD) begin errors++; $display("FAIL stall_word: got %h required abcd", inst); end
        @(posedge clk); #1;
        ref_mem[0] = 16'hABCD;
        mdl_idle = 1'b1;
    endtask

    task automatic test_ignored();
        do_start();
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h11, 1'b0, 0);
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        checks++; if (load_cnt !== 3'd1) begin errors++; $display("FAIL ign_start_cnt: got %0d required 1", load_cnt); end
        send_byte(8'h22, 1'b1, 0);
        checks++;
        if (load_done !== 1'b0 || setn !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL ign_last_lo: done=%b setn=%b ready=%b required 0 0 1", load_done, setn, load_ready);
        end
        send_byte(8'h22, 1'b0, 0);
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL ign_early_done: got %b required 0", load_done); end
        checks++; if (load_cnt !== 3'd2) begin errors++; $display("FAIL ign_cnt2: got %0d required 2", load_cnt); end
        send_byte(8'h33, 1'b0, 0);
        send_byte(8'h33, 1'b1, 0);
        checks++; if (load_done !== 1'b1 || load_cnt !== 3'd3) begin errors++; $display("FAIL ign_done: done=%b cnt=%0d required 1 3", load_done, load_cnt); end
        @(posedge clk); #1;
        ref_mem[0] = 16'h1111; ref_mem[1] = 16'h2222; ref_mem[2] = 16'h3333;
        mdl_idle = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = i[PMSB:0]; #1;
            checks++;
            if (inst !== ref_mem[i]) begin errors++; $display("FAIL ign_mem%0d: got %h required %h", i, inst, ref_mem[i]); end
        end
    endtask

    task automatic test_abort();
        do_start();
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h00 + i[7:0], 1'b0, 0);
            send_byte(8'hA0, 1'b0, 0);
        end
        @(negedge clk); rstn = 1'b0; #2;
        checks++; if (load_cnt !== 3'd0) begin errors++; $display("FAIL abort_cnt: got %0d required 0", load_cnt); end
        checks++; if (setn !== !BOOT || load_ready !== BOOT) begin errors++; $display("FAIL abort_state: setn=%b ready=%b required %b %b", setn, load_ready, !BOOT, BOOT); end
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        checks++; if (setn !== !BOOT || load_done !== 1'b0) begin errors++; $display("FAIL abort_after: setn=%b done=%b required %b 0", setn, load_done, !BOOT); end
        for (int i = 0; i < 3; i++) ref_mem[i] = 16'hA000 + 16'(i);
        mdl_idle = !BOOT;
        for (int i = 0; i < DEPTH; i++) begin
            pc = i[PMSB:0]; #1;
            checks++;
            if (inst !== ref_mem[i]) begin errors++; $display("FAIL abort_mem%0d: got %h required %h", i, inst, ref_mem[i]); end
        end
    endtask

    task automatic test_random();
        logic [15:0] w [$];
        int n, exp_cnt;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 7);
            w.delete();
            for (int i = 0; i < n; i++) w.push_back(16'($urandom));
            send_words(w, 3);
            exp_cnt = (n > DEPTH) ? DEPTH : n;
            checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL rnd%0d_done: got %b required 1", it, load_done); end
            checks++; if (load_cnt !== exp_cnt[PMSB+1:0]) begin errors++; $display("FAIL rnd%0d_cnt: got %0d required %0d", it, load_cnt, exp_cnt); end
            @(posedge clk); #1;
            checks++; if (setn !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL rnd%0d_resume: setn=%b done=%b required 1 0", it, setn, load_done); end
            model_load(w);
            for (int i = 0; i < DEPTH; i++) begin
                pc = i[PMSB:0]; #1;
                checks++;
                if (inst !== ref_mem[i]) begin errors++; $display("FAIL rnd%0d_mem%0d: got %h required %h", it, i, inst, ref_mem[i]); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;
        mdl_idle = !BOOT;
        test_reset();
        test_basic();
        test_wrap();
        test_fetch();
        test_stall();
        test_ignored();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
